// File: rtl/stream_checker.sv
// stream_checker -- sink side of the SDRAM stream test.
//
// Consumes 32-bit words read back from SDRAM, each one qualified by a
// single-cycle num_32_rdy strobe. It checks that the words form a contiguous
// +1 sequence that wraps at 2^32. The status/UART readout logic gets word and
// error counts, a sticky error flag and a capture of the first mismatch.
//
// Optional build macro: STREAM_CHECKER_RESYNC_EN
//   defined   : a mismatch in CHECK reseeds expected from the bad word (+1),
//               so a single skip or jump costs exactly one error.
//   undefined : a mismatch still advances expected by one, so every word
//               after an offset keeps counting as an error.
//
// Ports:
//   clk            system clock, rising edge
//   n_rst          synchronous active-low reset
//   enable         1 = armed, 0 = idle (strobes ignored)
//   clr            synchronous clear of counters/flags/captures, re-arms
//   stream_32      received data word
//   num_32_rdy     one-cycle strobe, stream_32 valid this cycle
//   checking       high while in CHECK
//   err_pulse      one-cycle pulse after a mismatching word
//   err_sticky     set on first mismatch, held until reset/clr
//   err_count      mismatch count, saturating at all-ones
//   word_count     accepted words (seed included), wrapping
//   expected_out   value expected for the next word
//   first_bad_data stream_32 at the first mismatch
//   first_bad_exp  expected value at the first mismatch
module stream_checker #(
  parameter logic [31:0] START_VALUE   = 32'h0000_0000,
  parameter bit          LOCK_ON_FIRST = 1'b0,
  parameter int          ERR_CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 enable,
  input  logic                 clr,
  input  logic [31:0]          stream_32,
  input  logic                 num_32_rdy,
  output logic                 checking,
  output logic                 err_pulse,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [31:0]          word_count,
  output logic [31:0]          expected_out,
  output logic [31:0]          first_bad_data,
  output logic [31:0]          first_bad_exp
);

  typedef enum logic [1:0] {IDLE, SEED, CHECK} state_t;

  localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;
  localparam logic [31:0]          WORD_ONE = 32'd1;

  state_t      state, state_nxt;
  logic        accept;
  logic        do_check;
  logic        mismatch;
  logic [31:0] cmp_val;
  logic [31:0] exp_nxt;

  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state plus the per-strobe decode shared with the datapath.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    do_check  = 1'b0;
    mismatch  = 1'b0;
    cmp_val   = expected_out;
    exp_nxt   = expected_out;

    if (clr) begin
      state_nxt = enable ? SEED : IDLE;
    end else if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = SEED;
        SEED:    if (num_32_rdy) state_nxt = CHECK;
        CHECK:   state_nxt = CHECK;
        default: state_nxt = IDLE;
      endcase
      accept = num_32_rdy && (state != IDLE);
    end

    if (state == SEED) begin
      // The seed word is compared with START_VALUE, not with the held
      // expected register, so a re-arm after a disable starts cleanly.
      cmp_val  = START_VALUE;
      do_check = accept && !LOCK_ON_FIRST;
      exp_nxt  = LOCK_ON_FIRST ? stream_32 + WORD_ONE : START_VALUE + WORD_ONE;
    end else begin
      do_check = accept;
      exp_nxt  = expected_out + WORD_ONE;
    end

    mismatch = do_check && (stream_32 != cmp_val);

`ifdef STREAM_CHECKER_RESYNC_EN
    if (mismatch && state == CHECK) exp_nxt = stream_32 + WORD_ONE;
`endif
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      err_pulse      <= 1'b0;
      err_sticky     <= 1'b0;
      err_count      <= '0;
      word_count     <= '0;
      expected_out   <= START_VALUE;
      first_bad_data <= '0;
      first_bad_exp  <= '0;
    end else if (clr) begin
      // clr wins over a simultaneous strobe; that word is dropped.
      err_pulse      <= 1'b0;
      err_sticky     <= 1'b0;
      err_count      <= '0;
      word_count     <= '0;
      expected_out   <= START_VALUE;
      first_bad_data <= '0;
      first_bad_exp  <= '0;
    end else begin
      err_pulse <= mismatch;
      if (accept) begin
        word_count   <= word_count + WORD_ONE;
        expected_out <= exp_nxt;
      end
      if (mismatch) begin
        err_sticky <= 1'b1;
        if (err_count != ERR_MAX) err_count <= err_count + ERR_ONE;
        if (!err_sticky) begin
          first_bad_data <= stream_32;
          first_bad_exp  <= cmp_val;
        end
      end
    end
  end

  assign checking = (state == CHECK);

endmodule

// File: tb/tb_stream_checker.sv
module tb_stream_checker;

`ifdef STREAM_CHECKER_RESYNC_EN
  localparam bit RS = 1'b1;
`else
  localparam bit RS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Three instances: 0 = LOCK_ON_FIRST=0, 1 = LOCK_ON_FIRST=1, 2 = ERR_CNT_W=4.
  logic        nr  [3];
  logic        en  [3];
  logic        cl  [3];
  logic        rdy [3];
  logic [31:0] dat [3];
  logic        ck_o[3], pu_o[3], st_o[3];
  logic [15:0] ec_o[3];
  logic [31:0] wc_o[3], eo_o[3], fbd_o[3], fbe_o[3];
  logic [3:0]  ec2;
  assign ec_o[2] = {12'h000, ec2};

  stream_checker #(.START_VALUE(32'h0), .LOCK_ON_FIRST(1'b0), .ERR_CNT_W(16)) u0 (
    .clk(clk), .n_rst(nr[0]), .enable(en[0]), .clr(cl[0]), .stream_32(dat[0]),
    .num_32_rdy(rdy[0]), .checking(ck_o[0]), .err_pulse(pu_o[0]), .err_sticky(st_o[0]),
    .err_count(ec_o[0]), .word_count(wc_o[0]), .expected_out(eo_o[0]),
    .first_bad_data(fbd_o[0]), .first_bad_exp(fbe_o[0]));

  stream_checker #(.START_VALUE(32'h0), .LOCK_ON_FIRST(1'b1), .ERR_CNT_W(16)) u1 (
    .clk(clk), .n_rst(nr[1]), .enable(en[1]), .clr(cl[1]), .stream_32(dat[1]),
    .num_32_rdy(rdy[1]), .checking(ck_o[1]), .err_pulse(pu_o[1]), .err_sticky(st_o[1]),
    .err_count(ec_o[1]), .word_count(wc_o[1]), .expected_out(eo_o[1]),
    .first_bad_data(fbd_o[1]), .first_bad_exp(fbe_o[1]));

  stream_checker #(.START_VALUE(32'h0), .LOCK_ON_FIRST(1'b0), .ERR_CNT_W(4)) u2 (
    .clk(clk), .n_rst(nr[2]), .enable(en[2]), .clr(cl[2]), .stream_32(dat[2]),
    .num_32_rdy(rdy[2]), .checking(ck_o[2]), .err_pulse(pu_o[2]), .err_sticky(st_o[2]),
    .err_count(ec2), .word_count(wc_o[2]), .expected_out(eo_o[2]),
    .first_bad_data(fbd_o[2]), .first_bad_exp(fbe_o[2]));

  typedef struct {
    int          d;
    string       nm;
    int          due;
    logic [31:0] wc;
    logic [15:0] ec;
    logic        st, pu, ck;
    logic [31:0] eo, fbd, fbe;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(string nm, string f, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s.%s got=%h want=%h", nm, f, act, want);
    end
  endtask

  // Monitor: pops every expectation that has come due and compares it with
  // the addressed instance's outputs.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      cmp(e.nm, "word_count",     wc_o[e.d],  e.wc);
      cmp(e.nm, "err_count",      32'(ec_o[e.d]), 32'(e.ec));
      cmp(e.nm, "err_sticky",     32'(st_o[e.d]), 32'(e.st));
      cmp(e.nm, "err_pulse",      32'(pu_o[e.d]), 32'(e.pu));
      cmp(e.nm, "checking",       32'(ck_o[e.d]), 32'(e.ck));
      cmp(e.nm, "expected_out",   eo_o[e.d],  e.eo);
      cmp(e.nm, "first_bad_data", fbd_o[e.d], e.fbd);
      cmp(e.nm, "first_bad_exp",  fbe_o[e.d], e.fbe);
    end
  end

  // Expectation for the outputs right after the next rising edge.
  task automatic ex(int d, string nm, logic [31:0] wc, logic [15:0] ec,
                    logic st, logic pu, logic ck, logic [31:0] eo,
                    logic [31:0] fbd, logic [31:0] fbe);
    exp_t x;
    x.d = d; x.nm = nm; x.due = cyc + 1;
    x.wc = wc; x.ec = ec; x.st = st; x.pu = pu; x.ck = ck;
    x.eo = eo; x.fbd = fbd; x.fbe = fbe;
    q.push_back(x);
  endtask

  task automatic step(int d, logic r, logic [31:0] v);
    @(negedge clk);
    rdy[d] = r;
    dat[d] = v;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      nr[i] = 1'b0; en[i] = 1'b0; cl[i] = 1'b0; rdy[i] = 1'b0; dat[i] = '0;
    end

    // Reset state on all instances.
    @(negedge clk);
    for (int i = 0; i < 3; i++) ex(i, "rst", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) nr[i] = 1'b1;

    // Instance 0: 100 words 0..99, one every 18 clocks.
    en[0] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(0, 1'b1, 32'(i));
      if (i == 0)  ex(0, "a0",  1,   0, 0, 0, 1, 1,   0, 0);
      if (i == 99) ex(0, "a99", 100, 0, 0, 0, 1, 100, 0, 0);
      repeat (17) step(0, 1'b0, 32'h0);
    end

    // clr with enable held: back to SEED with everything cleared.
    @(negedge clk); cl[0] = 1'b1;
    ex(0, "clr_a", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); cl[0] = 1'b0;

    // Sequence 0,1,2,5,6,7 back-to-back.
    step(0, 1'b1, 32'd0); ex(0, "c0", 1, 0, 0, 0, 1, 1, 0, 0);
    step(0, 1'b1, 32'd1); ex(0, "c1", 2, 0, 0, 0, 1, 2, 0, 0);
    step(0, 1'b1, 32'd2); ex(0, "c2", 3, 0, 0, 0, 1, 3, 0, 0);
    step(0, 1'b1, 32'd5); ex(0, "c5", 4, 1, 1, 1, 1, RS ? 32'd6 : 32'd4, 5, 3);
    step(0, 1'b1, 32'd6); ex(0, "c6", 5, RS ? 16'd1 : 16'd2, 1, !RS, 1, RS ? 32'd7 : 32'd5, 5, 3);
    step(0, 1'b1, 32'd7); ex(0, "c7", 6, RS ? 16'd1 : 16'd3, 1, !RS, 1, RS ? 32'd8 : 32'd6, 5, 3);
    step(0, 1'b0, 32'd0); ex(0, "c_idle", 6, RS ? 16'd1 : 16'd3, 1, 0, 1, RS ? 32'd8 : 32'd6, 5, 3);

    // clr together with a strobe of 9: the word is dropped.
    @(negedge clk); cl[0] = 1'b1; rdy[0] = 1'b1; dat[0] = 32'd9;
    ex(0, "clr_strobe", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); cl[0] = 1'b0; rdy[0] = 1'b1; dat[0] = 32'd0;
    ex(0, "d0", 1, 0, 0, 0, 1, 1, 0, 0);
    step(0, 1'b1, 32'd1); ex(0, "d1", 2, 0, 0, 0, 1, 2, 0, 0);
    step(0, 1'b0, 32'd0);

    // Instance 1: lock on first word, wrap through 2^32.
    en[1] = 1'b1;
    step(1, 1'b0, 32'h0);
    step(1, 1'b1, 32'hFFFF_FFFE); ex(1, "l0", 1, 0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0);
    step(1, 1'b1, 32'hFFFF_FFFF); ex(1, "l1", 2, 0, 0, 0, 1, 32'h0, 0, 0);
    step(1, 1'b1, 32'h0000_0000);
    step(1, 1'b1, 32'h0000_0001); ex(1, "l3", 4, 0, 0, 0, 1, 2, 0, 0);
    step(1, 1'b0, 32'h0);
    en[1] = 1'b0;
    step(1, 1'b1, 32'd100);
    step(1, 1'b1, 32'd200);
    step(1, 1'b1, 32'd300); ex(1, "disabled", 4, 0, 0, 0, 0, 2, 0, 0);
    step(1, 1'b0, 32'h0);
    en[1] = 1'b1;
    step(1, 1'b0, 32'h0);
    step(1, 1'b1, 32'd50); ex(1, "r50", 5, 0, 0, 0, 1, 51, 0, 0);
    step(1, 1'b1, 32'd51); ex(1, "r51", 6, 0, 0, 0, 1, 52, 0, 0);
    step(1, 1'b0, 32'h0);

    // Instance 2: 20 words of constant 7, all mismatching; count saturates.
    en[2] = 1'b1;
    step(2, 1'b0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      step(2, 1'b1, 32'd7);
      if (i == 0)  ex(2, "s0",  1,  1,  1, 1, 1, 1, 7, 0);
      if (i == 15) ex(2, "s15", 16, 15, 1, 1, 1, RS ? 32'd8 : 32'd16, 7, 0);
      if (i == 19) ex(2, "s19", 20, 15, 1, 1, 1, RS ? 32'd8 : 32'd20, 7, 0);
    end
    step(2, 1'b1, 32'd7);
    // Reset mid-stream, with a strobe in the same cycle.
    step(2, 1'b1, 32'd7); nr[2] = 1'b0;
    ex(2, "rst_mid", 0, 0, 0, 0, 0, 0, 0, 0);
    step(2, 1'b0, 32'h0); nr[2] = 1'b1;

    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
